std_mem_arbiter: RTL and testbench

Round-robin arbiter that shares the single port of a `std_mem_d1` instance between `NREQ` Calyx groups, each using the standard go/done handshake. The compiler instantiates it between group control logic and a memory whenever more than one group in a component accesses the same memory. The design is fully sequential:

- It performs one memory access at a time.
- It registers read data.
- It pulses the requester's `done` exactly once per access.

---
 rtl/std_arb_pkg.sv | 21 ++
 rtl/std_rr_pick.sv | 30 +++
 rtl/std_mem_arbiter.sv | 115 +++++++++++
 tb/tb_std_mem_arbiter.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/std_arb_pkg.sv
// Shared types and helpers for the std_mem_d1 round-robin arbiter.
package std_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        WAIT_WR = 2'd2,
        RESP    = 2'd3
    } arb_state_e;

    // Index width for n requesters; never below 1 bit.
    function automatic int unsigned clog2_min1(input int unsigned n);
        int unsigned w;
        w = 1;
        while ((32'd1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/std_rr_pick.sv
// Combinational round-robin selector: first set request after `last`, with wrap.
module std_rr_pick
    import std_arb_pkg::*;
#(
    parameter int unsigned NREQ = 2,
    localparam int unsigned IW = clog2_min1(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last,
    output logic            valid,
    output logic [IW-1:0]   idx
);

    int unsigned cand;

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        cand  = 0;
        // Offsets 1..NREQ visit every requester once, ending at `last` itself.
        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand = (32'(last) + k) % NREQ;
            if (!valid && req[IW'(cand)]) begin
                valid = 1'b1;
                idx   = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/std_mem_arbiter.sv
// Round-robin arbiter sharing one std_mem_d1 port between NREQ go/done groups.
module std_mem_arbiter
    import std_arb_pkg::*;
#(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned IDX_SIZE = 4,
    parameter int unsigned NREQ     = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req_go,
    input  logic [NREQ*IDX_SIZE-1:0] req_addr,
    input  logic [NREQ*WIDTH-1:0]    req_write_data,
    input  logic [NREQ-1:0]          req_write_en,
    output logic [NREQ-1:0]          req_done,
    output logic [WIDTH-1:0]         req_read_data,
    output logic [IDX_SIZE-1:0]      mem_addr0,
    output logic [WIDTH-1:0]         mem_write_data,
    output logic                     mem_write_en,
    input  logic [WIDTH-1:0]         mem_read_data,
    input  logic                     mem_done
);

    localparam int unsigned IW = clog2_min1(NREQ);

    arb_state_e          state_q;
    logic [IW-1:0]       grant_q;
    logic [IW-1:0]       last_q;
    logic                is_wr_q;
    logic [WIDTH-1:0]    rdata_q;

    logic                pick_valid;
    logic [IW-1:0]       pick_idx;
    logic [IDX_SIZE-1:0] sel_addr;
    logic [WIDTH-1:0]    sel_wdata;

    std_rr_pick #(
        .NREQ(NREQ)
    ) u_pick (
        .req  (req_go),
        .last (last_q),
        .valid(pick_valid),
        .idx  (pick_idx)
    );

    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant_q == IW'(i)) begin
                sel_addr  = req_addr[i*IDX_SIZE +: IDX_SIZE];
                sel_wdata = req_write_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= IW'(NREQ - 1);
            is_wr_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_valid) begin
                        grant_q <= pick_idx;
                        is_wr_q <= req_write_en[pick_idx];
                        state_q <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (is_wr_q) begin
                        state_q <= WAIT_WR;
                    end else begin
                        rdata_q <= mem_read_data;
                        state_q <= RESP;
                    end
                end
                WAIT_WR: begin
                    if (mem_done) begin
                        state_q <= RESP;
                    end
                end
                RESP: begin
                    last_q  <= grant_q;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_read_data = rdata_q;

    // Outputs decode registered state only; write strobe and done are masked during reset.
    always_comb begin
        mem_addr0      = '0;
        mem_write_data = '0;
        mem_write_en   = 1'b0;
        req_done       = '0;
        if (state_q == ACCESS || state_q == WAIT_WR) begin
            mem_addr0 = sel_addr;
        end
        if (state_q == ACCESS && is_wr_q) begin
            mem_write_data = sel_wdata;
            mem_write_en   = ~reset;
        end
        if (state_q == RESP && !reset) begin
            req_done[grant_q] = 1'b1;
        end
    end

endmodule

// File: tb/tb_std_mem_arbiter.sv
// Directed self-checking bench for std_mem_arbiter with a behavioural std_mem_d1.
module tb_std_mem_arbiter;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned IDX   = 4;
    localparam int unsigned NREQ  = 3;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic [NREQ-1:0]       req_go = '0;
    logic [NREQ*IDX-1:0]   req_addr = '0;
    logic [NREQ*WIDTH-1:0] req_write_data = '0;
    logic [NREQ-1:0]       req_write_en = '0;
    logic [NREQ-1:0]       req_done;
    logic [WIDTH-1:0]      req_read_data;
    logic [IDX-1:0]        mem_addr0;
    logic [WIDTH-1:0]      mem_write_data;
    logic                  mem_write_en;
    logic [WIDTH-1:0]      mem_read_data;
    logic                  mem_done = 1'b0;

    logic [WIDTH-1:0]      mem [16];
    logic                  pre_we = 1'b0;
    logic [IDX-1:0]        pre_addr = '0;
    logic [WIDTH-1:0]      pre_data = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    std_mem_arbiter #(
        .WIDTH(WIDTH),
        .IDX_SIZE(IDX),
        .NREQ(NREQ)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req_go        (req_go),
        .req_addr      (req_addr),
        .req_write_data(req_write_data),
        .req_write_en  (req_write_en),
        .req_done      (req_done),
        .req_read_data (req_read_data),
        .mem_addr0     (mem_addr0),
        .mem_write_data(mem_write_data),
        .mem_write_en  (mem_write_en),
        .mem_read_data (mem_read_data),
        .mem_done      (mem_done)
    );

    // std_mem_d1: combinational read, registered write and done.
    always @(posedge clk) begin
        if (pre_we) mem[pre_addr] <= pre_data;
        else if (mem_write_en) mem[mem_addr0] <= mem_write_data;
        mem_done <= mem_write_en;
    end
    assign mem_read_data = mem[mem_addr0];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic go, input logic we,
                           input logic [IDX-1:0] a, input logic [WIDTH-1:0] d);
        req_go[i] = go;
        req_write_en[i] = we;
        req_addr[i*IDX +: IDX] = a;
        req_write_data[i*WIDTH +: WIDTH] = d;
    endtask

    task automatic preload(input logic [IDX-1:0] a, input logic [WIDTH-1:0] d);
        pre_we = 1'b1;
        pre_addr = a;
        pre_data = d;
        tick();
        pre_we = 1'b0;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        req_go = '0;
        req_write_en = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick();
        tick();
        checks++; if (req_done !== 3'b000) begin errors++; $display("FAIL reset_done: got %b exp 000", req_done); end
        checks++; if (mem_write_en !== 1'b0) begin errors++; $display("FAIL reset_we: got %b exp 0", mem_write_en); end
        checks++; if (mem_addr0 !== 4'h0) begin errors++; $display("FAIL reset_addr: got %h exp 0", mem_addr0); end
        checks++; if (mem_write_data !== 32'h0) begin errors++; $display("FAIL reset_wdata: got %h exp 0", mem_write_data); end
        checks++; if (req_read_data !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h exp 0", req_read_data); end
        preload(4'd0, 32'h1000_0000);
        preload(4'd1, 32'h0000_00A5);
        preload(4'd2, 32'h2222_2222);
        preload(4'd3, 32'hDEAD_BEEF);
        reset = 1'b0;
    endtask

    task automatic test_single_read;
        set_req(0, 1'b1, 1'b0, 4'd3, 32'h0);
        tick();
        checks++; if (mem_addr0 !== 4'd3) begin errors++; $display("FAIL rd_addr: got %h exp 3", mem_addr0); end
        checks++; if (mem_write_en !== 1'b0) begin errors++; $display("FAIL rd_we_access: got %b exp 0", mem_write_en); end
        checks++; if (req_done !== 3'b000) begin errors++; $display("FAIL rd_early_done: got %b exp 000", req_done); end
        tick();
        checks++; if (req_done !== 3'b001) begin errors++; $display("FAIL rd_done: got %b exp 001", req_done); end
        checks++; if (req_read_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_data: got %h exp deadbeef", req_read_data); end
        checks++; if (mem_write_en !== 1'b0) begin errors++; $display("FAIL rd_we_resp: got %b exp 0", mem_write_en); end
        req_go[0] = 1'b0;
        tick();
        checks++; if (req_done !== 3'b000) begin errors++; $display("FAIL rd_done_once: got %b exp 000", req_done); end
    endtask

    task automatic test_single_write;
        set_req(1, 1'b1, 1'b1, 4'd5, 32'h1234_5678);
        tick();
        checks++; if (mem_write_en !== 1'b1) begin errors++; $display("FAIL wr_we: got %b exp 1", mem_write_en); end
        checks++; if (mem_addr0 !== 4'd5) begin errors++; $display("FAIL wr_addr: got %h exp 5", mem_addr0); end
        checks++; if (mem_write_data !== 32'h1234_5678) begin errors++; $display("FAIL wr_wdata: got %h exp 12345678", mem_write_data); end
        tick();
        checks++; if (mem_write_en !== 1'b0) begin errors++; $display("FAIL wr_we_once: got %b exp 0", mem_write_en); end
        checks++; if (mem_addr0 !== 4'd5) begin errors++; $display("FAIL wr_addr_hold: got %h exp 5", mem_addr0); end
        checks++; if (req_done !== 3'b000) begin errors++; $display("FAIL wr_early_done: got %b exp 000", req_done); end
        tick();
        checks++; if (req_done !== 3'b010) begin errors++; $display("FAIL wr_done: got %b exp 010", req_done); end
        set_req(1, 1'b0, 1'b0, 4'd5, 32'h1234_5678);
        tick();
        set_req(0, 1'b1, 1'b0, 4'd5, 32'h0);
        tick();
        tick();
        checks++; if (req_done !== 3'b001) begin errors++; $display("FAIL wr_rb_done: got %b exp 001", req_done); end
        checks++; if (req_read_data !== 32'h1234_5678) begin errors++; $display("FAIL wr_rb_data: got %h exp 12345678", req_read_data); end
        req_go[0] = 1'b0;
        tick();
    endtask

    task automatic test_fairness;
        logic [WIDTH-1:0] expd [3];
        logic [NREQ-1:0]  exp_done;
        int n;
        int exp_idx;
        expd[0] = 32'h1000_0000;
        expd[1] = 32'h0000_00A5;
        expd[2] = 32'h2222_2222;
        n = 0;
        do_reset();
        for (int i = 0; i < 3; i++) set_req(i, 1'b1, 1'b0, IDX'(i), 32'h0);
        for (int cyc = 0; cyc < 60 && n < 6; cyc++) begin
            tick();
            if (req_done !== 3'b000) begin
                exp_idx = n % 3;
                exp_done = 3'(1 << exp_idx);
                checks++; if (req_done !== exp_done) begin errors++; $display("FAIL fair_grant%0d: got %b exp %b", n, req_done, exp_done); end
                checks++; if (req_read_data !== expd[exp_idx]) begin errors++; $display("FAIL fair_data%0d: got %h exp %h", n, req_read_data, expd[exp_idx]); end
                n++;
            end
            req_go = ~req_done;
        end
        checks++; if (n != 6) begin errors++; $display("FAIL fair_timeout: got %0d grants exp 6", n); end
        req_go = '0;
        tick();
        tick();
    endtask

    task automatic test_read_hold;
        set_req(0, 1'b1, 1'b0, 4'd1, 32'h0);
        tick();
        tick();
        checks++; if (req_read_data !== 32'hA5) begin errors++; $display("FAIL hold_first: got %h exp a5", req_read_data); end
        req_go[0] = 1'b0;
        tick();
        set_req(1, 1'b1, 1'b1, 4'd2, 32'h0BAD_CAFE);
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++; if (req_read_data !== 32'hA5) begin errors++; $display("FAIL hold_cyc%0d: got %h exp a5", c, req_read_data); end
        end
        checks++; if (req_done !== 3'b010) begin errors++; $display("FAIL hold_wr_done: got %b exp 010", req_done); end
        set_req(1, 1'b0, 1'b0, 4'd2, 32'h0);
        tick();
        checks++; if (req_read_data !== 32'hA5) begin errors++; $display("FAIL hold_idle: got %h exp a5", req_read_data); end
        checks++; if (mem[2] !== 32'h0BAD_CAFE) begin errors++; $display("FAIL hold_mem: got %h exp 0badcafe", mem[2]); end
    endtask

    task automatic test_reset_mid_write;
        // Read by 0 first so the round-robin pointer sits at 0 before the reset.
        set_req(0, 1'b1, 1'b0, 4'd3, 32'h0);
        tick();
        tick();
        req_go[0] = 1'b0;
        tick();
        set_req(1, 1'b1, 1'b1, 4'd7, 32'h7777_7777);
        tick();
        tick();
        checks++; if (mem_addr0 !== 4'd7) begin errors++; $display("FAIL rst_wait_addr: got %h exp 7", mem_addr0); end
        reset = 1'b1;
        #1;
        checks++; if (req_done !== 3'b000) begin errors++; $display("FAIL rst_cycle_done: got %b exp 000", req_done); end
        tick();
        reset = 1'b0;
        req_go = '0;
        req_write_en = '0;
        #1;
        checks++; if (req_done !== 3'b000) begin errors++; $display("FAIL rst_no_done: got %b exp 000", req_done); end
        checks++; if (mem_addr0 !== 4'd0) begin errors++; $display("FAIL rst_idle_addr: got %h exp 0", mem_addr0); end
        set_req(0, 1'b1, 1'b0, 4'd3, 32'h0);
        set_req(1, 1'b1, 1'b0, 4'd1, 32'h0);
        tick();
        checks++; if (mem_addr0 !== 4'd3) begin errors++; $display("FAIL rst_grant_addr: got %h exp 3", mem_addr0); end
        tick();
        checks++; if (req_done !== 3'b001) begin errors++; $display("FAIL rst_grant_done: got %b exp 001", req_done); end
        checks++; if (req_read_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rst_grant_data: got %h exp deadbeef", req_read_data); end
        req_go = '0;
        tick();
        tick();
    endtask

    task automatic test_early_drop;
        set_req(0, 1'b1, 1'b1, 4'd9, 32'hCAFE_F00D);
        tick();
        checks++; if (mem_write_en !== 1'b1) begin errors++; $display("FAIL drop_we: got %b exp 1", mem_write_en); end
        req_go[0] = 1'b0;
        tick();
        checks++; if (req_done !== 3'b000) begin errors++; $display("FAIL drop_early_done: got %b exp 000", req_done); end
        tick();
        checks++; if (req_done !== 3'b001) begin errors++; $display("FAIL drop_done: got %b exp 001", req_done); end
        checks++; if (mem[9] !== 32'hCAFE_F00D) begin errors++; $display("FAIL drop_mem: got %h exp cafef00d", mem[9]); end
        req_write_en[0] = 1'b0;
        tick();
        checks++; if (req_done !== 3'b000) begin errors++; $display("FAIL drop_done_once: got %b exp 000", req_done); end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_single_write();
        test_fairness();
        test_read_hold();
        test_reset_mid_write();
        test_early_drop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got running exp finished");
        $fatal(1, "watchdog");
    end

endmodule
